// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_t   : sequencer FSM states
//   release_cycle : sequence-counter value at which channel i leaves reset
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StRun,
    StPass,
    StFail,
    StTimeout
  } seq_state_t;

  function automatic int unsigned release_cycle(input int unsigned i,
                                                input int unsigned hold_cycles,
                                                input int unsigned stagger);
    return hold_cycles + i * stagger;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, wins over en_i
//   en_i   : count enable
//   cnt_o  : registered count
// Saturate = 1 holds the count at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width    = 8,
  parameter bit          Saturate = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(Saturate && (&cnt_q))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Test-harness reset sequencer: releases NUM_CH active-low DUT resets in a
// staggered order, then counts run cycles under a watchdog and latches a
// sticky pass/fail/timeout verdict.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   sw_rst_req  : synchronous request to replay the whole reset sequence
//   test_done_i : test complete (only honoured in RUN)
//   test_fail_i : test failed (only honoured in RUN, beats done and timeout)
//   ch_rst_n_o  : per-channel active-low resets, one flop per channel
//   seq_done_o  : all channels released
//   cycle_cnt_o : saturating count of cycles spent in RUN
//   pass_o / fail_o / timeout_o : sticky verdict flags
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned STAGGER     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              test_done_i,
  input  logic              test_fail_i,
  output logic [NUM_CH-1:0] ch_rst_n_o,
  output logic              seq_done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o
);

  localparam int unsigned FirstRel = release_cycle(0, HOLD_CYCLES, STAGGER);
  localparam int unsigned LastRel  = release_cycle(NUM_CH - 1, HOLD_CYCLES, STAGGER);
  // One spare count above LastRel so the counter never saturates mid-sequence.
  localparam int unsigned SeqW     = $clog2(LastRel + 2);

  if (NUM_CH < 1) begin : g_chk_num_ch
    $fatal(1, "rst_seq_ctrl: NUM_CH must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $fatal(1, "rst_seq_ctrl: HOLD_CYCLES must be >= 1");
  end
  if (CNT_W < 32) begin : g_chk_cnt_w
    if ((TIMEOUT >> CNT_W) != 0) begin : g_chk_timeout
      $fatal(1, "rst_seq_ctrl: TIMEOUT must be < 2**CNT_W");
    end
  end

  seq_state_t        state_q, state_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              seq_done_q, seq_done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic [SeqW-1:0]   seq_cnt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [31:0]       seq_nxt;
  logic              in_seq;
  logic              in_run;

  assign in_seq  = (state_q == StHold) || (state_q == StRelease);
  assign in_run  = (state_q == StRun);
  // Value the sequence counter takes on this edge; release decisions use it
  // so each channel flop rises on exactly the edge its count is reached.
  assign seq_nxt = 32'(seq_cnt) + 32'd1;

  sat_counter #(
    .Width    (SeqW),
    .Saturate (1'b1)
  ) u_seq_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (sw_rst_req),
    .en_i  (in_seq),
    .cnt_o (seq_cnt)
  );

  // Enabled on the exit edge too, so the frozen value is one past the last
  // RUN cycle.
  sat_counter #(
    .Width    (CNT_W),
    .Saturate (1'b1)
  ) u_cyc_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (sw_rst_req),
    .en_i  (in_run),
    .cnt_o (cyc_cnt)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    seq_done_d = seq_done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;

    if (sw_rst_req) begin
      state_d    = StHold;
      ch_d       = '0;
      seq_done_d = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      unique case (state_q)
        StHold, StRelease: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (seq_nxt >= release_cycle(i, HOLD_CYCLES, STAGGER)) begin
              ch_d[i] = 1'b1;
            end
          end
          if (seq_nxt >= LastRel) begin
            state_d    = StRun;
            seq_done_d = 1'b1;
          end else if (seq_nxt >= FirstRel) begin
            state_d = StRelease;
          end
        end
        StRun: begin
          if (test_fail_i) begin
            state_d = StFail;
            fail_d  = 1'b1;
          end else if (test_done_i) begin
            state_d = StPass;
            pass_d  = 1'b1;
          end else if ((TIMEOUT != 0) && (cyc_cnt == CNT_W'(TIMEOUT - 1))) begin
            state_d   = StTimeout;
            timeout_d = 1'b1;
          end
        end
        default: begin
          // Terminal verdict states hold everything.
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHold;
      ch_q       <= '0;
      seq_done_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      seq_done_q <= seq_done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ch_rst_n_o  = ch_q;
  assign seq_done_o  = seq_done_q;
  assign cycle_cnt_o = cyc_cnt;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;

endmodule
